mac_sequencer: RTL

- Upstream control stage that feeds the shift-add Multiplier (DATA_WIDTH-bit unsigned operands, Start/Ready handshake, 2*DATA_WIDTH Product).
- Accepts a stream of operand pairs grouped into packets by a Last flag, and issues one multiplication per pair.
- Accumulates the products and emits one dot-product result per packet over a valid/ready output handshake.

---
 rtl/mac_sequencer_if.sv | 50 +++++
 rtl/mac_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer_if
//  Purpose  : Bundles the operand stream, Multiplier link and result stream
//             of the MAC sequencer.
//  Revision : 1.0 - initial release
//  Signals  :
//    InA/InB/InLast/InValid/InReady    operand-pair stream (valid/ready)
//    MulInputA/MulInputB/MulStart      operands and start to the Multiplier
//    MulProduct/MulReady               product and ready from the Multiplier
//    Result/ResultCount/ResultOverflow packet result fields
//    ResultValid/ResultReady           result handshake (valid/ready)
//  Modports :
//    slave  - the sequencer itself
//    master - the environment around it (source, Multiplier, sink)
// ============================================================================
interface mac_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   InA;
  logic [DATA_WIDTH-1:0]   InB;
  logic                    InLast;
  logic                    InValid;
  logic                    InReady;
  logic [DATA_WIDTH-1:0]   MulInputA;
  logic [DATA_WIDTH-1:0]   MulInputB;
  logic                    MulStart;
  logic [2*DATA_WIDTH-1:0] MulProduct;
  logic                    MulReady;
  logic [ACC_WIDTH-1:0]    Result;
  logic [COUNT_WIDTH-1:0]  ResultCount;
  logic                    ResultOverflow;
  logic                    ResultValid;
  logic                    ResultReady;

  modport slave (
    input  InA, InB, InLast, InValid, MulProduct, MulReady, ResultReady,
    output InReady, MulInputA, MulInputB, MulStart,
           Result, ResultCount, ResultOverflow, ResultValid
  );

  modport master (
    output InA, InB, InLast, InValid, MulProduct, MulReady, ResultReady,
    input  InReady, MulInputA, MulInputB, MulStart,
           Result, ResultCount, ResultOverflow, ResultValid
  );
endinterface
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer
//  Purpose  : Feeds operand pairs one at a time to a shift-add Multiplier,
//             accumulates the products of a packet (delimited by InLast) and
//             returns one dot-product result per packet.
//  Revision : 1.0 - initial release
//  Ports    :
//    Clk    in  clock, rising edge
//    Reset  in  synchronous active-high reset
//    bus    mac_sequencer_if.slave - operand stream, Multiplier link, result
// ============================================================================
module mac_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  mac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DROP = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACCUM     = 3'd4,
    S_OUT       = 3'd5
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_mul_a;
  logic [DATA_WIDTH-1:0]  r_mul_b;
  logic                   r_mul_start;
  logic                   r_last;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_ovf;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [ACC_WIDTH-1:0]   r_result;
  logic [COUNT_WIDTH-1:0] r_result_count;
  logic                   r_result_ovf;
  logic                   r_result_valid;

  logic                   w_accept;
  logic [ACC_WIDTH:0]     w_sum;
  logic [ACC_WIDTH-1:0]   w_acc_next;
  logic                   w_ovf_next;
  logic [COUNT_WIDTH-1:0] w_count_next;

  // Only accept a pair when the Multiplier is idle, so the start handshake
  // normally completes on the first ISSUE cycle.
  assign bus.InReady = (r_state == S_IDLE) && bus.MulReady;
  assign w_accept    = bus.InValid && bus.InReady;

  // One extra bit on the adder captures the carry-out for the sticky flag.
  assign w_sum        = {1'b0, r_acc}
                      + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){1'b0}}, bus.MulProduct};
  assign w_acc_next   = w_sum[ACC_WIDTH-1:0];
  assign w_ovf_next   = r_ovf | w_sum[ACC_WIDTH];
  assign w_count_next = (&r_count) ? r_count : r_count + COUNT_WIDTH'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_start    <= 1'b0;
      r_last         <= 1'b0;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_count        <= '0;
      r_result       <= '0;
      r_result_count <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mul_a     <= bus.InA;
            r_mul_b     <= bus.InB;
            r_last      <= bus.InLast;
            r_mul_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Only stalls when a reset left the Multiplier mid-operation.
          if (bus.MulReady) begin
            r_mul_start <= 1'b0;
            r_state     <= S_WAIT_DROP;
          end
        end
        S_WAIT_DROP: begin
          // The Multiplier's Ready drops only after the start edge, so it
          // cannot be trusted during this cycle.
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.MulReady) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc   <= w_acc_next;
          r_ovf   <= w_ovf_next;
          r_count <= w_count_next;
          if (r_last) begin
            r_result       <= w_acc_next;
            r_result_count <= w_count_next;
            r_result_ovf   <= w_ovf_next;
            r_result_valid <= 1'b1;
            r_state        <= S_OUT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (bus.ResultReady) begin
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_ovf          <= 1'b0;
            r_count        <= '0;
            r_state        <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MulInputA      = r_mul_a;
  assign bus.MulInputB      = r_mul_b;
  assign bus.MulStart       = r_mul_start;
  assign bus.Result         = r_result;
  assign bus.ResultCount    = r_result_count;
  assign bus.ResultOverflow = r_result_ovf;
  assign bus.ResultValid    = r_result_valid;

endmodule
`default_nettype wire
